adiabatic_phase_ctrl: RTL and testbench

Synchronous controller that drives one adiabatic datapath stage, such as the 16-bit XOR array, from the conventional CMOS side.
- Generates the four power-clock phases (clkpos1, clkpos2, clkneg1, clkneg2) from a single system clock.
- Launches operands into the stage through a valid/ready handshake.
- Captures the stage result and returns it through a second valid/ready handshake.
- Sits between the MIPS25 pipeline registers and the adiabatic ALU slices.

---
 rtl/adiabatic_phase_ctrl.sv | 168 ++++++++++++++++
 tb/tb_adiabatic_phase_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adiabatic_phase_ctrl.sv
// adiabatic_phase_ctrl
// Drives one adiabatic datapath stage from the CMOS side. It generates the
// four-phase power clock, launches operand pairs into the stage once per
// power-clock period, and returns the stage result through a valid/ready slot.
// Phase 2 lags phase 1 by one quarter. The operand window is open in IDLE and
// in the last cycle of q3, so each accepted pair owns exactly one period.

module adiabatic_phase_ctrl #(
  parameter int WIDTH       = 16,
  parameter int QUARTER_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] stage_res,
  output logic             clkpos1,
  output logic             clkpos2,
  output logic             clkneg1,
  output logic             clkneg2,
  output logic             ramp1,
  output logic             ramp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             busy
);

  localparam int QC_W = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;
  localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUARTER_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      q, q_nxt;
  logic [QC_W-1:0] qc, qc_nxt;
  logic            token;

  logic qend;
  logic win;
  logic cap;
  logic acc;
  logic run_nxt;

  assign qend = (qc == QC_LAST);

  // Operand window: always open while idle, otherwise only in the final
  // cycle of q3 so the next pair lines up with the start of q0.
  assign win = (state == IDLE) || ((state == RUN) && (q == 2'd3) && qend);

  // Result capture point: the stage output is settled at the end of q2.
  assign cap = (state == RUN) && (q == 2'd2) && qend && token;

  // The result slot must be empty (or draining) before a new pair is taken,
  // which guarantees the capture 3 quarters later never overwrites a result.
  // rst_n gates the handshake so nothing is offered while reset is held.
  assign in_ready = rst_n & win & en & (~out_valid | out_ready);
  assign acc      = in_valid & in_ready;

  // Next-state decode for the quarter/cycle counters.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    qc_nxt    = qc;
    case (state)
      IDLE: begin
        q_nxt  = 2'd0;
        qc_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (qend) begin
          qc_nxt = '0;
          if (q == 2'd3) begin
            q_nxt = 2'd0;
            // A period is never cut short; en is only sampled at its end.
            if (!en) state_nxt = IDLE;
          end else begin
            q_nxt = q + 2'd1;
          end
        end else begin
          qc_nxt = qc + QC_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = 2'd0;
        qc_nxt    = '0;
      end
    endcase
  end

  assign run_nxt = (state_nxt == RUN);

  // State, quarter index and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= 2'd0;
      qc    <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      qc    <= qc_nxt;
    end
  end

  // Phase outputs are decoded from the next state so they line up with
  // the registered q/qc values and leave the block straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkpos1 <= 1'b0;
      clkpos2 <= 1'b0;
      clkneg1 <= 1'b1;
      clkneg2 <= 1'b1;
      ramp1   <= 1'b0;
      ramp2   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      clkpos1 <= run_nxt & ~q_nxt[1];
      clkpos2 <= run_nxt & (q_nxt[1] ^ q_nxt[0]);
      clkneg1 <= ~(run_nxt & ~q_nxt[1]);
      clkneg2 <= ~(run_nxt & (q_nxt[1] ^ q_nxt[0]));
      ramp1   <= run_nxt & (q_nxt == 2'd0);
      ramp2   <= run_nxt & (q_nxt == 2'd1);
      busy    <= run_nxt;
    end
  end

  // Operand launch: the token marks whether the coming period carries data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      if (win) token <= acc;
      if (acc) begin
        op_a <= in_a;
        op_b <= in_b;
      end
    end
  end

  // Result slot: capture at end of q2, release when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (cap) begin
        out_res   <= stage_res;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adiabatic_phase_ctrl.sv
// Directed bench for adiabatic_phase_ctrl with an XOR stage model, Q = 4.
`timescale 1ns/1ps

module tb_adiabatic_phase_ctrl;

  localparam int W = 16;
  localparam int Q = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] op_a, op_b;
  logic [W-1:0] stage_res;
  logic         clkpos1, clkpos2, clkneg1, clkneg2, ramp1, ramp2;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [W-1:0] res_q[$];

  adiabatic_phase_ctrl #(.WIDTH(W), .QUARTER_CYC(Q)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .stage_res(stage_res),
    .clkpos1(clkpos1), .clkpos2(clkpos2), .clkneg1(clkneg1), .clkneg2(clkneg2),
    .ramp1(ramp1), .ramp2(ramp2),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .busy(busy)
  );

  // Stage model: combinational XOR array.
  assign stage_res = op_a ^ op_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && out_valid && out_ready) res_q.push_back(out_res);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair and wait (bounded) for the accepting edge; returns after it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int ok);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok == 1) tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int ok, n, cnt, k;
    int st[3];
    logic [W-1:0] ta[3];
    logic [W-1:0] tb[3];
    ta[0] = 16'h1234; tb[0] = 16'hFFFF;
    ta[1] = 16'h0000; tb[1] = 16'h0000;
    ta[2] = 16'h8001; tb[2] = 16'h7FFE;

    // ---------------- reset values ----------------
    en = 1'b1;
    tick();
    tick();
    chk("rst_clkpos1", clkpos1, 0);
    chk("rst_clkpos2", clkpos2, 0);
    chk("rst_clkneg1", clkneg1, 1);
    chk("rst_clkneg2", clkneg2, 1);
    chk("rst_ramp", {ramp1, ramp2}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_out_res", out_res, 0);

    // ---------------- free-running phases, no data ----------------
    rst_n = 1'b1;
    tick();
    for (k = 1; k <= 32; k++) begin
      n = (k - 1) % 16;
      chk($sformatf("ph_clkpos1_%0d", k), clkpos1, (n < 8) ? 1 : 0);
      chk($sformatf("ph_clkpos2_%0d", k), clkpos2, (n >= 4 && n < 12) ? 1 : 0);
      chk($sformatf("ph_clkneg1_%0d", k), clkneg1, (n < 8) ? 0 : 1);
      chk($sformatf("ph_clkneg2_%0d", k), clkneg2, (n >= 4 && n < 12) ? 0 : 1);
      chk($sformatf("ph_ramp1_%0d", k), ramp1, (n < 4) ? 1 : 0);
      chk($sformatf("ph_ramp2_%0d", k), ramp2, (n >= 4 && n < 8) ? 1 : 0);
      chk($sformatf("ph_in_ready_%0d", k), in_ready, (n == 15) ? 1 : 0);
      chk($sformatf("ph_busy_%0d", k), busy, 1);
      chk($sformatf("ph_out_valid_%0d", k), out_valid, 0);
      tick();
    end

    // ---------------- single transaction ----------------
    out_ready = 1'b1;
    send(16'hA5A5, 16'h0FF0, ok);
    chk("t2_accept", ok, 1);
    chk("t2_op_a", op_a, 16'hA5A5);
    chk("t2_op_b", op_b, 16'h0FF0);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t2_latency", n, 13);
    chk("t2_out_res", out_res, 16'hAA55);
    tick();
    chk("t2_one_cycle", out_valid, 0);

    // ---------------- back-to-back ----------------
    res_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb[i], ok);
      chk($sformatf("t3_accept_%0d", i), ok, 1);
      st[i] = cyc;
    end
    chk("t3_spacing_01", st[1] - st[0], 16);
    chk("t3_spacing_12", st[2] - st[1], 16);
    n = 0;
    while (res_q.size() < 3 && n < 80) begin
      tick();
      n++;
    end
    chk("t3_count", res_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < res_q.size()) chk($sformatf("t3_res_%0d", i), res_q[i], ta[i] ^ tb[i]);
    end

    // ---------------- backpressure, then drain + accept ----------------
    tick();
    out_ready = 1'b0;
    send(16'hF0F0, 16'h1111, ok);
    chk("t4_accept", ok, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t4_valid", out_valid, 1);
    chk("t4_res", out_res, 16'hE1E1);
    in_a = 16'h00FF;
    in_b = 16'h0F0F;
    in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready) cnt++;
      tick();
    end
    chk("t4_no_ready", cnt, 0);
    chk("t4_held_valid", out_valid, 1);
    chk("t4_held_res", out_res, 16'hE1E1);
    n = 0;
    while (!clkpos2 && n < 40) begin tick(); n++; end
    while (clkpos2 && n < 40) begin tick(); n++; end
    chk("t4_find_q3", n < 40, 1);
    tick();
    tick();
    tick();
    res_q.delete();
    out_ready = 1'b1;
    #1;
    chk("t4_window_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t4_drained", out_valid, 0);
    chk("t4_drain_count", res_q.size(), 1);
    if (res_q.size() > 0) chk("t4_drain_val", res_q[0], 16'hE1E1);
    chk("t4_new_op_a", op_a, 16'h00FF);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t4_latency", n, 13);
    chk("t4_new_res", out_res, 16'h0FF0);
    tick();

    // ---------------- en drop mid-q1 ----------------
    n = 0;
    while ((clkpos1 && clkpos2) && n < 40) begin tick(); n++; end
    while (!(clkpos1 && clkpos2) && n < 40) begin tick(); n++; end
    chk("t5_find_q1", n < 40, 1);
    tick();
    en = 1'b0;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    in_valid = 1'b1;
    cnt = 0;
    n = 1;
    while (busy && n < 40) begin
      if (in_ready) cnt++;
      tick();
      n++;
    end
    chk("t5_run_out", n, 12);
    chk("t5_no_ready", cnt, 0);
    chk("t5_idle_clkpos", {clkpos1, clkpos2}, 0);
    chk("t5_idle_clkneg", {clkneg1, clkneg2}, 2'b11);
    chk("t5_idle_ramp", {ramp1, ramp2}, 0);
    chk("t5_idle_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("t5_no_result", cnt, 0);
    in_valid = 1'b0;

    // ---------------- reset mid-q2 with token in flight ----------------
    en = 1'b1;
    send(16'h5555, 16'h3333, ok);
    chk("t6_accept", ok, 1);
    n = 0;
    while (!(clkpos2 && !clkpos1) && n < 40) begin tick(); n++; end
    chk("t6_find_q2", n < 40, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_clkpos", {clkpos1, clkpos2}, 0);
    chk("t6_clkneg", {clkneg1, clkneg2}, 2'b11);
    chk("t6_ramp", {ramp1, ramp2}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_op_a", op_a, 0);
    chk("t6_op_b", op_b, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_res", out_res, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("t6_no_result", cnt, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
